mpfifo_write_arbiter: RTL and testbench

MPFIFO_WRITE_ARBITER -- requirements
Module: mpfifo_write_arbiter

---
 rtl/mpfifo_pkg.sv | 16 +
 rtl/mpfifo_wait_monitor.sv | 52 +++++
 rtl/mpfifo_write_arbiter.sv | 121 ++++++++++++
 tb/tb_mpfifo_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpfifo_pkg.sv
// Shared widths and types for the multi-port FIFO write arbiter.
package mpfifo_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_NUM_WRITE_PORTS = 2;
    localparam int DEF_STARVE_LIMIT    = 16;
    localparam int GRANT_TOTAL_W       = 16;
    localparam int WAIT_CNT_W          = 8;

    typedef logic [GRANT_TOTAL_W-1:0] grant_total_t;
    typedef logic [WAIT_CNT_W-1:0]    wait_cnt_t;

    localparam wait_cnt_t WAIT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/mpfifo_wait_monitor.sv
// Per-requester saturating wait counter with a sticky starvation flag.
module mpfifo_wait_monitor
    import mpfifo_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic i_ready,
    input  logic i_clr,
    output logic o_starve
);

    wait_cnt_t r_cnt;
    wait_cnt_t w_cnt_next;
    logic      r_starve;
    logic      w_waiting;
    logic      w_set;

    // Next wait count; the flag sets only on the cycle the count lands on the limit.
    always_comb begin
        w_waiting  = i_valid && !i_ready;
        w_cnt_next = '0;
        if (w_waiting) begin
            w_cnt_next = (r_cnt == WAIT_CNT_MAX) ? r_cnt : r_cnt + WAIT_CNT_W'(1);
        end else begin
            w_cnt_next = '0;
        end
        w_set = w_waiting && (w_cnt_next == WAIT_CNT_W'(STARVE_LIMIT));
    end

    // Counter and sticky flag; a coincident set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_starve <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_set) begin
                r_starve <= 1'b1;
            end else if (i_clr) begin
                r_starve <= 1'b0;
            end else begin
                r_starve <= r_starve;
            end
        end
    end

    assign o_starve = r_starve;

endmodule

// File: rtl/mpfifo_write_arbiter.sv
// Round-robin arbiter routing up to NUM_WRITE_PORTS requester beats per cycle
// onto the write ports of a multi-ported FIFO, with starvation tracking.
module mpfifo_write_arbiter
    import mpfifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int NUM_WRITE_PORTS = DEF_NUM_WRITE_PORTS,
    parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_WRITE_PORTS-1:0]            wr_en,
    output logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WRITE_PORTS-1:0]            wr_ready,
    output logic [NUM_REQ-1:0]                    starve,
    input  logic [NUM_REQ-1:0]                    starve_clr,
    output logic [GRANT_TOTAL_W-1:0]              grant_total
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]                    r_rr_ptr;
    grant_total_t                        r_grant_total;
    logic [PTR_W-1:0]                    w_rr_next;
    logic [PTR_W-1:0]                    w_last_idx;
    logic [NUM_REQ-1:0]                  w_grant;
    logic [NUM_WRITE_PORTS-1:0]          w_wr_en;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] w_wr_data;
    int                                  w_slots;
    int                                  w_grant_cnt;
    int                                  w_pos  [NUM_REQ];
    int                                  w_rank [NUM_REQ];

    // A requester's rank is the number of valid requesters ahead of it in scan
    // order; rank doubles as its write-port index when it wins a slot.
    always_comb begin
        w_grant     = '0;
        w_wr_en     = '0;
        w_wr_data   = '0;
        w_slots     = 0;
        w_grant_cnt = 0;
        w_last_idx  = r_rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos[i]  = 0;
            w_rank[i] = 0;
        end
        if (rst_n) begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                w_slots = w_slots + int'(wr_ready[p]);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                w_pos[i] = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr))
                                                 : (i + NUM_REQ - int'(r_rr_ptr));
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    w_rank[i] = w_rank[i] + ((req_valid[j] && (w_pos[j] < w_pos[i])) ? 1 : 0);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                w_grant[i]  = req_valid[i] && (w_rank[i] < w_slots);
                w_grant_cnt = w_grant_cnt + (w_grant[i] ? 1 : 0);
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    w_wr_en[p] = w_wr_en[p] | (w_grant[i] && (w_rank[i] == p));
                    w_wr_data[p*DATA_WIDTH +: DATA_WIDTH] = w_wr_data[p*DATA_WIDTH +: DATA_WIDTH] |
                        ((w_grant[i] && (w_rank[i] == p)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                          : {DATA_WIDTH{1'b0}});
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                w_last_idx = (w_grant[i] && (w_rank[i] == w_grant_cnt - 1)) ? PTR_W'(i) : w_last_idx;
            end
        end else begin
            w_grant     = '0;
            w_grant_cnt = 0;
        end
    end

    // Pointer advance past the last winner, wrapping for non-power-of-two counts.
    always_comb begin
        if (w_grant_cnt > 0) begin
            w_rr_next = (w_last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_last_idx + PTR_W'(1);
        end else begin
            w_rr_next = r_rr_ptr;
        end
    end

    // Round-robin pointer and accepted-beat total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_grant_total <= '0;
        end else begin
            r_rr_ptr      <= w_rr_next;
            r_grant_total <= r_grant_total + GRANT_TOTAL_W'(w_grant_cnt);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_mon
        mpfifo_wait_monitor #(
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_mon (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_valid  (req_valid[g]),
            .i_ready  (w_grant[g]),
            .i_clr    (starve_clr[g]),
            .o_starve (starve[g])
        );
    end

    assign req_ready   = w_grant;
    assign wr_en       = w_wr_en;
    assign wr_data     = w_wr_data;
    assign grant_total = r_grant_total;

endmodule

// File: tb/tb_mpfifo_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's writes,
// and a negedge monitor compares them and checks per-requester beat order.
module tb_mpfifo_write_arbiter;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int NWP = 2;
    localparam int SL  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NWP-1:0]   wr_en;
    logic [NWP*DW-1:0] wr_data;
    logic [NWP-1:0]   wr_ready;
    logic [NR-1:0]    starve;
    logic [NR-1:0]    starve_clr;
    logic [15:0]      grant_total;

    typedef struct {
        logic [NWP-1:0]    en;
        logic [NWP*DW-1:0] data;
        logic [NR-1:0]     rdy;
        logic [NR-1:0]     stv;
        logic [15:0]       gt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_rr = 0;
    int   m_gt = 0;
    int   m_wait[NR];
    bit   m_starve[NR];
    int   m_seq[NR];
    bit   m_pending[NR];
    int   mon_seq[NR];

    mpfifo_write_arbiter #(
        .DATA_WIDTH      (DW),
        .NUM_REQ         (NR),
        .NUM_WRITE_PORTS (NWP),
        .STARVE_LIMIT    (SL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .starve      (starve),
        .starve_clr  (starve_clr),
        .grant_total (grant_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int i);
        return {8'(i), 24'(m_seq[i])};
    endfunction

    // One arbitration cycle: drive inputs, predict the outcome, advance the model.
    task automatic drive(input logic [NR-1:0] v, input logic [NWP-1:0] r, input logic [NR-1:0] clr);
        int   order[$];
        int   slots;
        int   ng;
        int   idx;
        bit   set;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        req_valid  = v;
        wr_ready   = r;
        starve_clr = clr;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = beat(i);
        slots = 0;
        for (int p = 0; p < NWP; p++) slots += int'(r[p]);
        for (int k = 0; k < NR; k++) begin
            idx = (m_rr + k) % NR;
            if (v[idx]) order.push_back(idx);
        end
        ng = (order.size() < slots) ? order.size() : slots;
        e.en = '0; e.data = '0; e.rdy = '0;
        for (int p = 0; p < ng; p++) begin
            e.en[p] = 1'b1;
            e.data[p*DW +: DW] = beat(order[p]);
            e.rdy[order[p]] = 1'b1;
        end
        for (int i = 0; i < NR; i++) e.stv[i] = m_starve[i];
        e.gt = 16'(m_gt);
        exp_q.push_back(e);
        if (ng > 0) m_rr = (order[ng-1] + 1) % NR;
        m_gt = (m_gt + ng) % 65536;
        for (int i = 0; i < NR; i++) begin
            set = 1'b0;
            if (v[i] && !e.rdy[i]) begin
                m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
                set = (m_wait[i] == SL);
            end else begin
                m_wait[i] = 0;
            end
            if (set) m_starve[i] = 1'b1;
            else if (clr[i]) m_starve[i] = 1'b0;
            if (e.rdy[i]) m_seq[i]++;
            m_pending[i] = v[i] && !e.rdy[i];
        end
    endtask

    // Mid-cycle reset pulse lasting until the next drive call.
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 128'(wr_en), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        e.en = '0; e.data = '0; e.rdy = '0; e.stv = '0; e.gt = '0;
        exp_q.push_back(e);
        m_rr = 0;
        m_gt = 0;
        for (int i = 0; i < NR; i++) begin
            m_wait[i] = 0; m_starve[i] = 1'b0; m_pending[i] = 1'b0;
        end
    endtask

    // Monitor: compare predicted outputs and check per-requester beat sequence.
    initial begin : monitor
        exp_t e;
        int   id;
        int   sq;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_en", 128'(wr_en), 128'(e.en));
                chk("wr_data", 128'(wr_data), 128'(e.data));
                chk("req_ready", 128'(req_ready), 128'(e.rdy));
                chk("starve", 128'(starve), 128'(e.stv));
                chk("grant_total", 128'(grant_total), 128'(e.gt));
                chk("write_without_space", 128'(wr_en & ~wr_ready), 128'(0));
                for (int p = 0; p < NWP; p++) begin
                    if (wr_en[p]) begin
                        id = int'(wr_data[p*DW+24 +: 8]);
                        sq = int'(wr_data[p*DW +: 24]);
                        if (id < NR) begin
                            chk("beat_order", 128'(sq), 128'(mon_seq[id] % (1 << 24)));
                            mon_seq[id]++;
                        end else begin
                            chk("beat_id", 128'(id), 128'(0));
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [NR-1:0]  v;
        logic [NR-1:0]  clr;
        logic [NWP-1:0] r;
        int             n;
        for (int i = 0; i < NR; i++) begin
            m_wait[i] = 0; m_starve[i] = 1'b0; m_seq[i] = 0; m_pending[i] = 1'b0; mon_seq[i] = 0;
        end
        rst_n = 1'b0; req_valid = '0; req_data = '0; wr_ready = '0; starve_clr = '0;
        #1;
        chk("reset_wr_en", 128'(wr_en), 128'(0));
        chk("reset_req_ready", 128'(req_ready), 128'(0));
        chk("reset_wr_data", 128'(wr_data), 128'(0));
        chk("reset_grant_total", 128'(grant_total), 128'(0));
        chk("reset_starve", 128'(starve), 128'(0));

        // All four valid, both ports ready: two pairs then total of four.
        drive(4'b1111, 2'b11, 4'b0000);
        #1 chk("pair1_ready", 128'(req_ready), 128'(4'b0011));
        drive(4'b1111, 2'b11, 4'b0000);
        #1 chk("pair2_ready", 128'(req_ready), 128'(4'b1100));
        drive(4'b0000, 2'b00, 4'b0000);
        #1 chk("pair_total", 128'(grant_total), 128'(4));

        // One port ready: single grants in scan order on port 0.
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 2'b01, 4'b0000);
            #1;
            chk("single_ready", 128'(req_ready), 128'(1 << k));
            chk("single_wr_en", 128'(wr_en), 128'(2'b01));
        end

        // Wrap-around: pointer at 3, requesters 3 and 0 valid.
        drive(4'b0100, 2'b01, 4'b0000);
        drive(4'b1001, 2'b11, 4'b0000);
        #1;
        chk("wrap_ready", 128'(req_ready), 128'(4'b1001));
        chk("wrap_port0_id", 128'(wr_data[24 +: 8]), 128'(3));
        chk("wrap_port1_id", 128'(wr_data[DW+24 +: 8]), 128'(0));

        // Starvation: FIFO full for four cycles, flag sticky past grant, then cleared.
        for (int k = 0; k < 4; k++) drive(4'b0010, 2'b00, 4'b0000);
        drive(4'b0010, 2'b01, 4'b0000);
        #1;
        chk("starve_set", 128'(starve), 128'(4'b0010));
        chk("starve_grant", 128'(req_ready), 128'(4'b0010));
        drive(4'b0000, 2'b00, 4'b0010);
        drive(4'b0000, 2'b00, 4'b0000);
        #1 chk("starve_cleared", 128'(starve), 128'(4'b0000));

        // Random traffic with a mid-run reset pulse.
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                do_reset();
                drive(4'b0110, 2'b11, 4'b0000);
                #1;
                chk("post_reset_total", 128'(grant_total), 128'(0));
                chk("post_reset_ready", 128'(req_ready), 128'(4'b0110));
            end else begin
                for (int i = 0; i < NR; i++) begin
                    v[i]   = m_pending[i] ? 1'b1 : ($urandom_range(0, 2) != 0);
                    clr[i] = ($urandom_range(0, 7) == 0);
                end
                n = $urandom_range(0, NWP);
                r = NWP'((1 << n) - 1);
                drive(v, r, clr);
            end
        end

        drive(4'b0000, 2'b00, 4'b0000);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
